// File: rtl/inst_axi_responder_pkg.sv
// Shared AXI constants and AR-register layout for the instruction-side fetch responder.
// Downstream blocks import this package in place of a common.vh header.
package inst_axi_responder_pkg;

  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_PROT_INST  = 3'b100;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [3:0] AXI_CACHE_ALL  = 4'b1111;
  localparam logic [3:0] AXI_CACHE_NONE = 4'b0000;

  typedef struct packed {
    logic        valid;
    logic        cache;
    logic [31:0] addr;
  } ar_reg_t;

  function automatic logic [3:0] ar_cache_bits(input logic cacheable);
    return cacheable ? AXI_CACHE_ALL : AXI_CACHE_NONE;
  endfunction

endpackage

// File: rtl/inst_axi_responder.sv
// Converts inst_req/inst_addr_ok fetches into single-beat AXI4 reads and returns the
// data in request order, with a credit counter bounding fetches in flight.
module inst_axi_responder
  import inst_axi_responder_pkg::*;
#(
  parameter int         MAX_OUTSTANDING = 2,
  parameter logic [3:0] AXI_ID          = 4'd0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_cache,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic [31:0] inst_rdata,
  output logic        inst_data_ok,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] perfcnt_inst_wait
);

  localparam int               CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  ar_reg_t          ar_q, ar_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             data_ok_q, data_ok_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [31:0]      perf_q, perf_d;

  logic credit_ok;
  logic accept;
  logic r_fire;

  // Error responses are deliberately dropped; rid/rlast carry no information
  // because every read uses one ID and one beat.
  logic unused_r_fields;
  assign unused_r_fields = ^{rid, rlast, (rresp != AXI_RESP_OKAY)};

  assign rready  = 1'b1;
  assign r_fire  = rvalid;

  // A returning beat frees a credit in the same cycle, so a full counter can still accept.
  assign credit_ok    = (cnt_q < CNT_MAX) || (r_fire && (cnt_q == CNT_MAX));
  assign inst_addr_ok = (!ar_q.valid || arready) && credit_ok;
  assign accept       = inst_req && inst_addr_ok;

  always_comb begin
    ar_d      = ar_q;
    cnt_d     = cnt_q;
    data_ok_d = r_fire;
    rdata_d   = rdata_q;
    perf_d    = perf_q;

    if (accept) begin
      ar_d.valid = 1'b1;
      ar_d.addr  = inst_addr;
      ar_d.cache = inst_cache;
    end else if (ar_q.valid && arready) begin
      ar_d.valid = 1'b0;
    end

    case ({accept, r_fire})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    if (r_fire) begin
      rdata_d = rdata;
    end

    if ((cnt_q != '0) && !rvalid) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ar_q      <= '0;
      cnt_q     <= '0;
      data_ok_q <= 1'b0;
      rdata_q   <= 32'd0;
      perf_q    <= 32'd0;
    end else begin
      ar_q      <= ar_d;
      cnt_q     <= cnt_d;
      data_ok_q <= data_ok_d;
      rdata_q   <= rdata_d;
      perf_q    <= perf_d;
    end
  end

  assign arid              = AXI_ID;
  assign araddr            = ar_q.addr;
  assign arlen             = 8'd0;
  assign arsize            = AXI_SIZE_4B;
  assign arburst           = AXI_BURST_INCR;
  assign arlock            = 2'b00;
  assign arcache           = ar_cache_bits(ar_q.cache);
  assign arprot            = AXI_PROT_INST;
  assign arvalid           = ar_q.valid;
  assign inst_data_ok      = data_ok_q;
  assign inst_rdata        = rdata_q;
  assign perfcnt_inst_wait = perf_q;

endmodule

// File: tb/tb_inst_axi_responder.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// transaction-level model of the fetch protocol, with an emulated AXI slave.
module tb_inst_axi_responder;

  localparam int MAX = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic        inst_cache;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic [31:0] inst_rdata;
  logic        inst_data_ok;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [31:0] perfcnt_inst_wait;

  inst_axi_responder #(.MAX_OUTSTANDING(MAX), .AXI_ID(4'd0)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_cache(inst_cache), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_rdata(inst_rdata), .inst_data_ok(inst_data_ok),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
    .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready), .perfcnt_inst_wait(perfcnt_inst_wait)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int errorCount = 0;

  // Reference model: fetches accepted but not returned, pending AR, expected return.
  logic [31:0] pendingQ[$];
  logic        mArValid;
  logic [31:0] mArAddr;
  logic        mArCache;
  logic        mDataOk;
  logic [31:0] mRdata;
  logic [31:0] mPerf;
  // Emulated slave: addresses handshaken on AR awaiting their R beat.
  logic [31:0] slaveQ[$];

  logic        sReq, sCache, sArready, sRvAllow, sForceErr;
  logic [31:0] sAddr;
  int          acceptCount;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    case (a)
      32'h1FC0_0000: return 32'h3C08_BFC0;
      32'h0000_0100: return 32'hAAAA_0100;
      32'h0000_0104: return 32'hBBBB_0104;
      32'h0000_0200: return 32'hDEAD_BEEF;
      default:       return {a[15:0] ^ 16'h5A5A, a[31:16]} + 32'h0000_1357;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic setStim(input logic req, input logic [31:0] addr, input logic cache,
                         input logic ardy, input logic rvAllow);
    sReq = req; sAddr = addr; sCache = cache; sArready = ardy; sRvAllow = rvAllow;
  endtask

  // One clock cycle: drive inputs, check DUT against the model mid-cycle, advance the model.
  task automatic applyStimulus();
    logic expOk, acc, rv;
    @(posedge clk);
    #1;
    inst_req   = sReq;
    inst_addr  = sAddr;
    inst_cache = sCache;
    arready    = sArready;
    rv         = (slaveQ.size() > 0) && sRvAllow;
    rvalid     = rv;
    rdata      = rv ? memWord(slaveQ[0]) : 32'h0BAD_0BAD;
    rresp      = sForceErr ? 2'b10 : 2'($urandom_range(0, 3));
    rid        = 4'd0;
    rlast      = rv;
    #4;
    expOk = (!mArValid || arready) &&
            ((pendingQ.size() < MAX) || (rv && pendingQ.size() == MAX));
    checkOutput("inst_addr_ok", {31'd0, inst_addr_ok}, {31'd0, expOk});
    checkOutput("arvalid", {31'd0, arvalid}, {31'd0, mArValid});
    if (mArValid) begin
      checkOutput("araddr", araddr, mArAddr);
      checkOutput("arcache", {28'd0, arcache}, {28'd0, (mArCache ? 4'b1111 : 4'b0000)});
    end
    checkOutput("inst_data_ok", {31'd0, inst_data_ok}, {31'd0, mDataOk});
    if (mDataOk) checkOutput("inst_rdata", inst_rdata, mRdata);
    checkOutput("perfcnt", perfcnt_inst_wait, mPerf);
    checkOutput("rready", {31'd0, rready}, 32'd1);

    acc = inst_req && expOk;
    if (acc) acceptCount++;
    if (pendingQ.size() != 0 && !rv) mPerf = mPerf + 32'd1;
    if (arvalid && arready) slaveQ.push_back(araddr);
    mDataOk = rv;
    if (rv) begin
      void'(slaveQ.pop_front());
      if (pendingQ.size() == 0) begin
        checkOutput("model_underflow", 32'd1, 32'd0);
        mRdata = 32'h0;
      end else begin
        mRdata = memWord(pendingQ.pop_front());
      end
    end
    if (acc) begin
      mArValid = 1'b1;
      mArAddr  = inst_addr;
      mArCache = inst_cache;
      pendingQ.push_back(inst_addr);
    end else if (mArValid && arready) begin
      mArValid = 1'b0;
    end
  endtask

  task automatic drain();
    setStim(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      if (pendingQ.size() == 0 && !mDataOk) break;
      applyStimulus();
    end
    checkOutput("drain_empty", pendingQ.size(), 32'd0);
    applyStimulus();
  endtask

  initial begin
    resetn = 1'b0;
    inst_req = 1'b0; inst_cache = 1'b0; inst_addr = 32'h0;
    arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00; rid = 4'd0; rlast = 1'b0;
    mArValid = 1'b0; mArAddr = 32'h0; mArCache = 1'b0; mDataOk = 1'b0; mRdata = 32'h0;
    mPerf = 32'h0; sForceErr = 1'b0; acceptCount = 0;
    setStim(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_arvalid", {31'd0, arvalid}, 32'd0);
    checkOutput("rst_araddr", araddr, 32'd0);
    checkOutput("rst_arcache", {28'd0, arcache}, 32'd0);
    checkOutput("rst_data_ok", {31'd0, inst_data_ok}, 32'd0);
    checkOutput("rst_rdata", inst_rdata, 32'd0);
    checkOutput("rst_perf", perfcnt_inst_wait, 32'd0);
    resetn = 1'b1;

    $display("[TB] single fetch");
    setStim(1'b1, 32'h1FC0_0000, 1'b0, 1'b1, 1'b1);
    applyStimulus();
    drain();

    $display("[TB] credit stall");
    acceptCount = 0;
    for (int i = 0; i < 4; i++) begin
      setStim(1'b1, 32'h0000_1000 + 32'(i * 4), 1'b0, 1'b1, 1'b0);
      applyStimulus();
    end
    checkOutput("stall_accepts", acceptCount, 32'd2);
    setStim(1'b1, 32'h0000_1008, 1'b0, 1'b1, 1'b1);
    applyStimulus();
    checkOutput("stall_release_accept", acceptCount, 32'd3);
    drain();

    $display("[TB] AR backpressure");
    setStim(1'b1, 32'h0040_0010, 1'b0, 1'b0, 1'b1);
    applyStimulus();
    for (int i = 0; i < 5; i++) begin
      setStim(i[0], 32'h0040_0020 + 32'(i * 4), 1'b1, 1'b0, 1'b1);
      applyStimulus();
      checkOutput("held_araddr", araddr, 32'h0040_0010);
    end
    drain();

    $display("[TB] cacheable");
    setStim(1'b1, 32'h0000_0300, 1'b1, 1'b0, 1'b1);
    applyStimulus();
    setStim(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus();
    checkOutput("c_arcache", {28'd0, arcache}, 32'hF);
    checkOutput("c_arprot", {29'd0, arprot}, 32'h4);
    checkOutput("c_arlen", {24'd0, arlen}, 32'h0);
    checkOutput("c_arsize", {29'd0, arsize}, 32'h2);
    checkOutput("c_arburst", {30'd0, arburst}, 32'h1);
    checkOutput("c_arlock", {30'd0, arlock}, 32'h0);
    checkOutput("c_arid", {28'd0, arid}, 32'h0);
    drain();

    $display("[TB] back-to-back");
    setStim(1'b1, 32'h0000_0100, 1'b0, 1'b1, 1'b1);
    applyStimulus();
    setStim(1'b1, 32'h0000_0104, 1'b0, 1'b1, 1'b1);
    applyStimulus();
    setStim(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    applyStimulus();
    applyStimulus();
    checkOutput("b2b_first_ok", {31'd0, inst_data_ok}, 32'd1);
    checkOutput("b2b_first_data", inst_rdata, 32'hAAAA_0100);
    applyStimulus();
    checkOutput("b2b_second_ok", {31'd0, inst_data_ok}, 32'd1);
    checkOutput("b2b_second_data", inst_rdata, 32'hBBBB_0104);
    drain();

    $display("[TB] error response");
    sForceErr = 1'b1;
    setStim(1'b1, 32'h0000_0200, 1'b0, 1'b1, 1'b1);
    applyStimulus();
    drain();
    checkOutput("err_data", inst_rdata, 32'hDEAD_BEEF);
    sForceErr = 1'b0;

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      setStim(($urandom_range(0, 3) != 0), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
              1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 2) != 0));
      applyStimulus();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/inst_axi_responder.md
# inst_axi_responder

Instruction-side responder for the core's `inst_req`/`inst_addr_ok` fetch protocol. It accepts fetch address requests, converts each one into a single-beat AXI4 read, and returns the fetched word on `inst_rdata` with a one-cycle `inst_data_ok` pulse, strictly in request order. It sits between the fetch stage and the AXI interconnect, and bounds in-flight fetches with a credit counter.

## Interface
- `MAX_OUTSTANDING`, 2: maximum number of accepted requests whose data has not yet returned. Range 1..4.
- `AXI_ID`, 4'd0: constant value driven on `arid`.
- `clk`  in  1  clock.
- `resetn`  in  1  reset; synchronous, active-low.
- `inst_req`  in  1  fetch request valid. The requester may withdraw it before `inst_addr_ok`.
- `inst_cache`  in  1  cacheable attribute of the request.
- `inst_addr`  in  32  physical fetch address, word-aligned.
- `inst_addr_ok`  out  1  request accepted this cycle when `inst_req` is also high.
- `inst_rdata`  out  32  returned instruction word.
- `inst_data_ok`  out  1  one-cycle pulse; `inst_rdata` is valid in that cycle.
- `arid`  out  4  read address ID.
- `araddr`  out  32  read address.
- `arlen`  out  8  burst length.
- `arsize`  out  3  transfer size.
- `arburst`  out  2  burst type.
- `arlock`  out  2  lock.
- `arcache`  out  4  cache attributes.
- `arprot`  out  3  protection.
- `arvalid`  out  1  read address valid.
- `arready`  in  1  read address ready.
- `rid`  in  4  read data ID; ignored.
- `rdata`  in  32  read data.
- `rresp`  in  2  read response.
- `rlast`  in  1  last beat; every burst is a single beat.
- `rvalid`  in  1  read data valid.
- `rready`  out  1  read data ready.
- `perfcnt_inst_wait`  out  32  count of cycles with outstanding>0 and no `rvalid`.

## Operation
- **Constant AR fields:** `arid=AXI_ID`, `arlen=0`, `arsize=3'b010`, `arburst=2'b01`, `arlock=0`, `arprot=3'b100`.
- **`arcache`:** 4'b1111 if the latched `inst_cache`=1, else 4'b0000.
- **`rready`:** tied to 1. The fetch side never back-pressures data.
- **AR register:** holds `araddr` and the cache bit, and drives `arvalid`.
  - Loaded on accept (`inst_req && inst_addr_ok`); sets `arvalid`.
  - Clears `arvalid` on `arvalid && arready` unless a new accept loads it in the same cycle.
  - Once `arvalid` is set, `araddr`/`arcache` stay stable until `arready`, so withdrawal of `inst_req` never affects AXI.
- **`cnt`:** width clog2(MAX_OUTSTANDING+1).
  - +1 on accept, −1 on `rvalid && rready`.
  - On both in the same cycle, `cnt` is unchanged.
- **`inst_addr_ok`:** `(!arvalid || arready) && (cnt < MAX_OUTSTANDING || (rvalid && cnt == MAX_OUTSTANDING))`. It is purely combinational from state and the AXI inputs, and independent of `inst_req`.
- **Return path:** on `rvalid`, register `rdata` into `inst_rdata` and pulse `inst_data_ok` next cycle.
  - A non-OKAY `rresp` still returns the data and pulses `inst_data_ok`. No error signalling; the error is dropped.
- **Ordering:** a single ID with single beats gives in-order returns. No reordering logic.
- **`perfcnt_inst_wait`:** increments when `cnt != 0 && !rvalid`. Wraps at 2^32.

## Timing
- **Reset values:** `arvalid=0`, `araddr=0`, `arcache=0`, `cnt=0`, `inst_data_ok=0`, `inst_rdata=0`, `perfcnt_inst_wait=0`.
- **Reset mid-operation:** reset applies to the whole SoC, interconnect included. Stale `rvalid` after reset is not supported.
- **Request path:** accept in cycle T → `arvalid=1` in T+1.
  - With `arready` always 1, back-to-back accepts are possible every cycle up to the credit limit.
- **Data return latency:** `rvalid` in cycle R → `inst_data_ok`/`inst_rdata` in R+1. Minimum accept-to-data is 3 cycles (T accept, T+1 AR handshake, T+2 `rvalid`, T+3 data_ok).
- **Credit-limit boundary:** with `cnt=MAX_OUTSTANDING` and no `rvalid`, `inst_addr_ok=0`. A `rvalid` in that cycle permits accept in the same cycle.
- **Held AR:** with `arvalid=1 && !arready`, `inst_addr_ok=0`.
- **Withdrawn request:** `inst_req` high then low with no `inst_addr_ok` → no state change.

## Structure
- **Shared header:** AXI constants belong in the shared `common.vh`: `AXI_SIZE_4B`, `AXI_BURST_INCR`, `AXI_PROT_INST`, `AXI_RESP_OKAY`.
- **Module structure:** single flat module; no sub-module needed. The credit counter and AR register are small enough to stay inline.

## Test plan
- **Single fetch:** reset, then `inst_req=1` with addr 0x1FC00000, cache=0; `arready=1`; `rvalid` 2 cycles later with `rdata`=0x3C08BFC0.
  - Required: `araddr`=0x1FC00000, `arcache`=0, `inst_data_ok` one cycle after `rvalid` with `inst_rdata`=0x3C08BFC0, `cnt` back to 0.
- **Credit stall:** MAX=2; 3 consecutive requests, `rvalid` withheld.
  - Required: exactly 2 accepts, then `inst_addr_ok=0`.
  - On the first `rvalid`, the third request is accepted in that same cycle.
- **AR backpressure:** `arready=0` for 5 cycles after accept of 0x00400010.
  - Required: `arvalid` and `araddr` stay stable, `inst_addr_ok=0` throughout; `inst_req` dropping has no effect.
- **Cacheable attribute:** `inst_cache=1`.
  - Required: `arcache`=4'b1111, `arprot`=3'b100, `arlen`=0, `arsize`=3'b010.
- **In-order back-to-back:** addrs 0x100/0x104 accepted in consecutive cycles; `rvalid` in consecutive cycles with data A, B.
  - Required: `inst_data_ok` for two consecutive cycles with A then B.
- **Error response and perf counter:** `rresp`=2'b10 with data 0xDEADBEEF.
  - Required: data still returned.
  - `perfcnt_inst_wait` equals the number of cycles with `cnt>0` and no `rvalid`.
